tqvp_prism_cnt_bank: RTL
========================

// Module: tqvp_prism_cnt_bank
// PURPOSE
//  Parametrised countdown-counter bank for the PRISM peripheral: NUM_CH preloadable down-counters,
//  each stepped and reloaded by PRISM FSM output strobes, feeding zero flags back as FSM inputs.
//  Adds per-channel auto-reload, per-channel masked interrupts and CPU-visible counts.
//  Sits beside the prism controller inside the TinyQV peripheral; register file on the 6-bit bus.
// PARAMETERS
//  NUM_CH  4   number of counter channels, legal 1..6
//  CNT_W   27  counter width in bits, legal 1..32
// PORTS
//  clk           in   1       peripheral clock (64 MHz nominal)
//  rst_n         in   1       reset, synchronous, active-low
//  address       in   6       register byte address
//  data_in       in   32      write data
//  data_write_n  in   2       11 none, 10 = 32-bit write (only width honoured; 00/01 ignored)
//  data_read_n   in   2       unused (reads have no side effects)
//  data_out      out  32      read data, combinational from address
//  data_ready    out  1       tied 1
//  dec_i         in   NUM_CH  per-channel decrement strobe (PRISM output)
//  load_i        in   NUM_CH  per-channel reload strobe (PRISM output)
//  enable_i      in   1       FSM enable; gates load_i
//  halt_i        in   1       FSM halted; freezes all counting, loading and prescaler
//  zero_o        out  NUM_CH  count==0 per channel (to PRISM in_data)
//  irq_o         out  1       |(pend & irq_en)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): counts, preloads, irq_en, pend, mode = 0; zero_o all 1; irq_o 0.
//  Map: 0x00 CTRL: rd [NUM_CH-1:0]=zero_o; wr bit31=1 clears all counts and pend (one cycle).
//   0x04 IRQ_EN [NUM_CH-1:0] RW. 0x08 PEND [NUM_CH-1:0] RO, write-1-to-clear. 0x0C MODE [NUM_CH-1:0]
//   auto-reload RW. 0x10+4*ch COUNT ch RW. 0x28+4*ch PRELOAD ch RW. Unmapped/absent ch: read 0, wr ignored.
//  Data widths: reads zero-extended from CNT_W; writes truncated to CNT_W / NUM_CH bits.
//  Per channel, each cycle, priority high->low:
//   1 CPU write to COUNT or CTRL clear -> count <= value; no event.
//   2 halt_i=1 -> hold.
//   3 dec_i & tick & count!=0 -> count-1; if count==1: event; if MODE[ch] count <= preload instead.
//   4 load_i & enable_i -> count <= preload (dec at zero falls through to load).
//   5 else hold. dec at count==0 without load: hold, no event, no wrap.
//  Event: pend[ch] set next cycle; set beats same-cycle W1C. CTRL clear beats set.
//  Auto-reload with preload==0: count stays 0, event still raised on 1->0.
//  zero_o, irq_o derived combinationally from registered state (no extra latency stage).
// CONFIGURATION
//  PRISM_CNT_PRESCALE_EN defined: CTRL[23:16] RW 8-bit PRESCALE; free-running 8-bit down counter
//   (frozen by halt_i) reloads to PRESCALE at 0; tick=1 only when it is 0 -> dec honoured every
//   PRESCALE+1 cycles. Reset PRESCALE=0 (tick every cycle). load_i not prescaled.
//  Undefined: tick=1 constantly; CTRL[23:16] reads 0, writes ignored.
// STRUCTURE
//  Package prism_cnt_pkg: register offsets (CTRL, IRQ_EN, PEND, MODE, COUNT_BASE, PRELOAD_BASE),
//   MAX_CH=6, write-code constant WR32=2'b10.
//  Sub-module prism_cnt_channel (CNT_W): count/preload regs, priority logic, event output;
//   instantiated NUM_CH times by generate. Top holds decode, PEND/IRQ_EN/MODE, prescaler.
// TESTING
//  1 PRELOAD0=3, load_i[0]+enable_i, then dec_i[0] x3 -> count 3,2,1,0; zero_o[0]=1; PEND[0]=1.
//  2 IRQ_EN=1, event ch0 -> irq_o=1; write PEND=1 -> irq_o=0 next cycle; event same cycle as W1C -> stays 1.
//  3 MODE[1]=1, PRELOAD1=2, COUNT1=2, dec_i[1] every cycle -> 2,1,2,1...; PEND[1] set each wrap.
//  4 halt_i=1 with dec_i/load_i active -> counts frozen; load_i with enable_i=0 -> no reload.
//  5 COUNT0 write 5 same cycle as dec_i[0] -> count 5; CTRL bit31 -> all counts 0, PEND 0.
//  6 PRESCALE_EN: PRESCALE=3, dec_i[0] held, COUNT0=8 -> decrements once per 4 cycles; undefined build: per cycle.

Source files
------------

// File: rtl/prism_cnt_pkg.sv
// Shared constants for the PRISM countdown-counter bank: register map,
// channel limit and the bus write code.
package prism_cnt_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MAX_CH = 6;

    localparam logic [ADDR_W-1:0] ADDR_CTRL         = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN       = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_PEND         = 6'h08;
    localparam logic [ADDR_W-1:0] ADDR_MODE         = 6'h0C;
    localparam logic [ADDR_W-1:0] ADDR_COUNT_BASE   = 6'h10;
    localparam logic [ADDR_W-1:0] ADDR_PRELOAD_BASE = 6'h28;

    // data_write_n code for a 32-bit write; every other code is ignored
    localparam logic [1:0] WR32 = 2'b10;

    // Byte address of channel ch's COUNT register
    function automatic logic [ADDR_W-1:0] count_addr(input int unsigned ch);
        return ADDR_COUNT_BASE + ADDR_W'(4 * ch);
    endfunction

    // Byte address of channel ch's PRELOAD register
    function automatic logic [ADDR_W-1:0] preload_addr(input int unsigned ch);
        return ADDR_PRELOAD_BASE + ADDR_W'(4 * ch);
    endfunction

endpackage

// File: rtl/tqvp_prism_cnt_bank_if.sv
// TinyQV peripheral register bus seen by the counter bank.
//   address      6-bit byte address
//   data_in      32-bit write data
//   data_write_n write width code (2'b10 = 32-bit write)
//   data_read_n  read width code (reads have no side effects)
//   data_out     32-bit read data
//   data_ready   always ready
interface tqvp_prism_cnt_bank_if;
    import prism_cnt_pkg::*;

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [1:0]        data_write_n;
    logic [1:0]        data_read_n;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;

    modport master (
        output address, data_in, data_write_n, data_read_n,
        input  data_out, data_ready
    );

    modport slave (
        input  address, data_in, data_write_n, data_read_n,
        output data_out, data_ready
    );

endinterface

// File: rtl/prism_cnt_channel.sv
// One countdown channel: count and preload registers plus the per-cycle
// update priority (CPU write > halt > decrement > load > hold).
//   cnt_wr/cnt_wr_val  CPU COUNT write or bank clear (value already zeroed)
//   pre_wr/pre_wr_val  CPU PRELOAD write
//   halt               freeze count
//   dec, tick          decrement request and prescaler tick
//   load               reload request (already gated by FSM enable)
//   auto_reload        reload from preload on reaching zero
//   count, preload     registered state
//   event_c            1->0 transition this cycle (combinational)
module prism_cnt_channel #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_wr,
    input  logic [CNT_W-1:0] cnt_wr_val,
    input  logic             pre_wr,
    input  logic [CNT_W-1:0] pre_wr_val,
    input  logic             halt,
    input  logic             dec,
    input  logic             tick,
    input  logic             load,
    input  logic             auto_reload,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] preload,
    output logic             event_c
);

    logic [CNT_W-1:0] count_d;

    // Next count; a decrement at zero is not taken so a pending load wins
    always_comb begin
        count_d = count;
        event_c = 1'b0;
        if (cnt_wr) begin
            count_d = cnt_wr_val;
        end else if (halt) begin
            count_d = count;
        end else if (dec && tick && (count != '0)) begin
            if (count == CNT_W'(1)) begin
                event_c = 1'b1;
                count_d = auto_reload ? preload : '0;
            end else begin
                count_d = count - CNT_W'(1);
            end
        end else if (load) begin
            count_d = preload;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            preload <= '0;
        end else begin
            count <= count_d;
            if (pre_wr) begin
                preload <= pre_wr_val;
            end
        end
    end

endmodule

// File: rtl/tqvp_prism_cnt_bank.sv
// PRISM countdown-counter bank: NUM_CH preloadable down-counters driven by
// FSM strobes, zero flags back to the FSM, masked interrupts, CPU registers.
// Optional feature: define PRISM_CNT_PRESCALE_EN for an 8-bit decrement
// prescaler in CTRL[23:16].
//   clk, rst_n  clock, synchronous active-low reset
//   bus         register bus (slave)
//   dec_i       per-channel decrement strobe
//   load_i      per-channel reload strobe
//   enable_i    FSM enable, gates load_i
//   halt_i      FSM halted, freezes counting/loading/prescaler
//   zero_o      per-channel count==0
//   irq_o       any pending and enabled channel
module tqvp_prism_cnt_bank
    import prism_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    tqvp_prism_cnt_bank_if.slave bus,
    input  logic [NUM_CH-1:0]   dec_i,
    input  logic [NUM_CH-1:0]   load_i,
    input  logic                enable_i,
    input  logic                halt_i,
    output logic [NUM_CH-1:0]   zero_o,
    output logic                irq_o
);

    logic              we_c;
    logic              clr_c;
    logic              tick_c;
    logic [NUM_CH-1:0] irq_en_q;
    logic [NUM_CH-1:0] pend_q;
    logic [NUM_CH-1:0] mode_q;
    logic [NUM_CH-1:0] evt_c;
    logic [NUM_CH-1:0] w1c_c;
    logic [CNT_W-1:0]  count_q   [NUM_CH];
    logic [CNT_W-1:0]  preload_q [NUM_CH];
    logic [DATA_W-1:0] rdata_c;
    logic              unused_c;

    assign we_c  = (bus.data_write_n == WR32);
    assign clr_c = we_c && (bus.address == ADDR_CTRL) && bus.data_in[31];
    assign w1c_c = (we_c && (bus.address == ADDR_PEND)) ? bus.data_in[NUM_CH-1:0] : '0;

    assign bus.data_ready = 1'b1;
    assign bus.data_out   = rdata_c;
    assign irq_o          = |(pend_q & irq_en_q);
    assign unused_c       = ^{bus.data_read_n, bus.data_in};

`ifdef PRISM_CNT_PRESCALE_EN
    logic [7:0] prescale_q;
    logic [7:0] psc_q;

    // Free-running prescaler; a tick is the cycle it sits at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_q <= '0;
            psc_q      <= '0;
        end else begin
            if (we_c && (bus.address == ADDR_CTRL)) begin
                prescale_q <= bus.data_in[23:16];
            end
            if (!halt_i) begin
                psc_q <= (psc_q == 8'd0) ? prescale_q : psc_q - 8'd1;
            end
        end
    end

    assign tick_c = (psc_q == 8'd0);
`else
    assign tick_c = 1'b1;
`endif

    // Mask registers; event set wins over W1C, bank clear wins over set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
        end else begin
            if (we_c && (bus.address == ADDR_IRQ_EN)) begin
                irq_en_q <= bus.data_in[NUM_CH-1:0];
            end
            if (we_c && (bus.address == ADDR_MODE)) begin
                mode_q <= bus.data_in[NUM_CH-1:0];
            end
            if (clr_c) begin
                pend_q <= '0;
            end else begin
                pend_q <= (pend_q & ~w1c_c) | evt_c;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic cnt_wr_c;
        logic pre_wr_c;

        assign cnt_wr_c = clr_c || (we_c && (bus.address == count_addr(g)));
        assign pre_wr_c = we_c && (bus.address == preload_addr(g));

        prism_cnt_channel #(.CNT_W(CNT_W)) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .cnt_wr      (cnt_wr_c),
            .cnt_wr_val  (clr_c ? {CNT_W{1'b0}} : bus.data_in[CNT_W-1:0]),
            .pre_wr      (pre_wr_c),
            .pre_wr_val  (bus.data_in[CNT_W-1:0]),
            .halt        (halt_i),
            .dec         (dec_i[g]),
            .tick        (tick_c),
            .load        (load_i[g] && enable_i),
            .auto_reload (mode_q[g]),
            .count       (count_q[g]),
            .preload     (preload_q[g]),
            .event_c     (evt_c[g])
        );

        assign zero_o[g] = (count_q[g] == '0);
    end

    // Read mux; unmapped, unaligned and absent-channel addresses read 0
    always_comb begin
        rdata_c = '0;
        case (bus.address)
            ADDR_CTRL: begin
                rdata_c[NUM_CH-1:0] = zero_o;
`ifdef PRISM_CNT_PRESCALE_EN
                rdata_c[23:16] = prescale_q;
`endif
            end
            ADDR_IRQ_EN: rdata_c[NUM_CH-1:0] = irq_en_q;
            ADDR_PEND:   rdata_c[NUM_CH-1:0] = pend_q;
            ADDR_MODE:   rdata_c[NUM_CH-1:0] = mode_q;
            default:     ;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.address == count_addr(i)) begin
                rdata_c = DATA_W'(count_q[i]);
            end
            if (bus.address == preload_addr(i)) begin
                rdata_c = DATA_W'(preload_q[i]);
            end
        end
    end

endmodule
